// File: rtl/sync_filter_multi.sv
// rtl/sync_filter_multi.sv - multi-channel input synchronizer with glitch filter and edge pulses
module sync_filter_multi #(
    parameter int               WIDTH      = 4,
    parameter int               STAGES     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL  = {WIDTH{1'b0}},
    parameter int               FILTER_LEN = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_in,
    input  logic             hold,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] filt_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             change_any
);

    // A single-sample filter still needs a 1-bit counter to keep the array legal.
    localparam int            CW      = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

    logic [WIDTH-1:0] chain_q [STAGES];
    logic [WIDTH-1:0] filt_q, filt_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             change_q, change_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];

    assign sync_out   = chain_q[STAGES-1];
    assign filt_out   = filt_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign change_any = change_q;

    // Synchronizer shift chain; runs regardless of hold so the raw view stays live.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++) begin
                chain_q[s] <= RESET_VAL;
            end
        end else begin
            chain_q[0] <= async_in;
            for (int s = 1; s < STAGES; s++) begin
                chain_q[s] <= chain_q[s-1];
            end
        end
    end

    // Per-channel stability counter: filt follows only after FILTER_LEN differing samples.
    always_comb begin
        filt_d   = filt_q;
        rise_d   = '0;
        fall_d   = '0;
        change_d = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        if (!hold) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_out[i] == filt_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_MAX) begin
                    filt_d[i] = sync_out[i];
                    cnt_d[i]  = '0;
                    rise_d[i] = sync_out[i];
                    fall_d[i] = ~sync_out[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
            change_d = |{rise_d, fall_d};
        end
    end

    // Filter state and pulse registers; reset never yields a pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q   <= RESET_VAL;
            rise_q   <= '0;
            fall_q   <= '0;
            change_q <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            filt_q   <= filt_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            change_q <= change_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule
